// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and state encodings for the audio sample path
// Holds the load frame header, the loader and UART receiver state encodings,
// and the sample memory geometry defaults shared with the PWM player.
package audio_pkg;

    localparam logic [7:0] HEADER       = 8'hA5;
    localparam int         MEM_SIZE_DEF = 3901;
    localparam int         ADDR_W_DEF   = 20;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sample_loader_if.sv
// rtl/uart_sample_loader_if.sv - sample memory write port and load status bundle
// Signals: mem_we/mem_addr/mem_data (memory write strobe, address, byte),
// busy (load in progress), load_done/load_error (one-cycle result pulses),
// sample_count (length of the last good load).
// master: driven by the loader; slave: seen by the memory and player.
interface uart_sample_loader_if #(
    parameter int ADDR_W = 20
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              busy;
    logic              load_done;
    logic              load_error;
    logic [ADDR_W-1:0] sample_count;

    modport master (
        output mem_we, mem_addr, mem_data, busy, load_done, load_error, sample_count
    );

    modport slave (
        input mem_we, mem_addr, mem_data, busy, load_done, load_error, sample_count
    );
endinterface

// File: rtl/uart_sample_loader_uart_rx.sv
// rtl/uart_sample_loader_uart_rx.sv - 8N1 UART receiver with 16x oversampling
// Ports: clk, rst (sync active-high), rx_line (async serial in, idle high),
// rx_data (received byte), rx_valid (one-cycle byte-ready, cycle after stop sample),
// rx_frame_err (one-cycle pulse when the stop bit samples low).
module uart_rx
    import audio_pkg::*;
#(
    parameter int CLK_HZ = 12288000,
    parameter int BAUD   = 38400
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err
);
    localparam int DIV   = CLK_HZ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             rx_s1, rx_s2;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    rx_state_t        state, state_n;
    logic [3:0]       tick_cnt, tick_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shreg, sh_n;
    logic             valid_n, ferr_n;

    assign tick    = (div_cnt == DIV_W'(DIV - 1));
    assign rx_data = shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            div_cnt      <= '0;
            state        <= RX_IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_s1        <= rx_line;
            rx_s2        <= rx_s1;
            // Baud phase restarts at the start edge so tick 8 lands mid start bit.
            div_cnt      <= (state == RX_IDLE || tick) ? '0 : div_cnt + 1'b1;
            state        <= state_n;
            tick_cnt     <= tick_n;
            bit_cnt      <= bit_n;
            shreg        <= sh_n;
            rx_valid     <= valid_n;
            rx_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (!rx_s2) begin
                    state_n = RX_START;
                    tick_n  = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (tick_cnt == 4'd7) begin
                        // Line back high at mid start bit: a glitch, not a byte.
                        state_n = rx_s2 ? RX_IDLE : RX_DATA;
                        tick_n  = '0;
                        bit_n   = '0;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    tick_n = tick_cnt + 1'b1;
                    if (tick_cnt == 4'd15) begin
                        sh_n  = {rx_s2, shreg[7:1]};
                        bit_n = bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state_n = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    tick_n = tick_cnt + 1'b1;
                    if (tick_cnt == 4'd15) begin
                        valid_n = rx_s2;
                        ferr_n  = !rx_s2;
                        state_n = RX_IDLE;
                    end
                end
            end
            default: state_n = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/uart_sample_loader.sv
// rtl/uart_sample_loader.sv - loads framed PCM samples from UART into sample memory
// Ports: CLK, RESET (sync active-high), uart_rx (async serial in),
// bus (master side: memory write port, busy, load_done/load_error pulses, sample_count).
// Frame: A5, len lo, len hi, len data bytes, checksum (sum of data mod 256).
module uart_sample_loader
    import audio_pkg::*;
#(
    parameter int CLK_HZ      = 12288000,
    parameter int BAUD        = 38400,
    parameter int MEM_SIZE    = MEM_SIZE_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 122880
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 uart_rx,
    uart_sample_loader_if.master bus
);
    localparam logic [31:0] MEM_LIMIT   = MEM_SIZE;
    localparam logic [31:0] TIMEOUT_LIM = TIMEOUT_CYC;

    logic [7:0]        rx_data;
    logic              rx_valid, rx_frame_err;

    load_state_t       state, state_n;
    logic [15:0]       len, len_n, new_len;
    logic [ADDR_W-1:0] cnt, cnt_n, cnt_p1;
    logic [7:0]        csum, csum_n;
    logic              we_r, we_n, done_r, done_n, err_r, err_n;
    logic [ADDR_W-1:0] addr_r, addr_n, count_r, count_n;
    logic [7:0]        data_r, data_n;
    logic [31:0]       timer;
    logic              timeout;

    uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
        .clk          (CLK),
        .rst          (RESET),
        .rx_line      (uart_rx),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err)
    );

    assign new_len = {rx_data, len[7:0]};
    assign cnt_p1  = cnt + 1'b1;
    assign timeout = (state != IDLE) && (timer == TIMEOUT_LIM);

    assign bus.mem_we       = we_r;
    assign bus.mem_addr     = addr_r;
    assign bus.mem_data     = data_r;
    assign bus.busy         = (state != IDLE);
    assign bus.load_done    = done_r;
    assign bus.load_error   = err_r;
    assign bus.sample_count = count_r;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            len     <= '0;
            cnt     <= '0;
            csum    <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            count_r <= '0;
            timer   <= '0;
        end else begin
            state   <= state_n;
            len     <= len_n;
            cnt     <= cnt_n;
            csum    <= csum_n;
            we_r    <= we_n;
            addr_r  <= addr_n;
            data_r  <= data_n;
            done_r  <= done_n;
            err_r   <= err_n;
            count_r <= count_n;
            // Timer holds cycles elapsed since the last byte-ready (1 in the cycle
            // after it), so the error lands TIMEOUT_CYC+1 cycles after byte-ready.
            if (rx_valid)                 timer <= 32'd1;
            else if (state == IDLE)       timer <= '0;
            else if (timer != TIMEOUT_LIM) timer <= timer + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        len_n   = len;
        cnt_n   = cnt;
        csum_n  = csum;
        we_n    = 1'b0;
        addr_n  = addr_r;
        data_n  = data_r;
        done_n  = 1'b0;
        err_n   = 1'b0;
        count_n = count_r;
        if (rx_valid) begin
            case (state)
                IDLE: if (rx_data == HEADER) state_n = LEN_LO;
                LEN_LO: begin
                    len_n[7:0] = rx_data;
                    state_n    = LEN_HI;
                end
                LEN_HI: begin
                    if (new_len == 16'd0 || {16'd0, new_len} > MEM_LIMIT) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        len_n   = new_len;
                        cnt_n   = '0;
                        csum_n  = '0;
                        state_n = DATA;
                    end
                end
                DATA: begin
                    we_n   = 1'b1;
                    addr_n = cnt;
                    data_n = rx_data;
                    cnt_n  = cnt_p1;
                    csum_n = csum + rx_data;
                    if (cnt_p1 == ADDR_W'(len)) state_n = CSUM;
                end
                CSUM: begin
                    if (rx_data == csum) begin
                        done_n  = 1'b1;
                        count_n = ADDR_W'(len);
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && (rx_frame_err || timeout)) begin
            err_n   = 1'b1;
            state_n = IDLE;
        end
    end
endmodule

// File: tb/tb_uart_sample_loader.sv
// tb/tb_uart_sample_loader.sv - scoreboard bench for uart_sample_loader
module tb_uart_sample_loader;
    import audio_pkg::*;

    localparam int BAUD        = 9600;
    localparam int CLK_HZ      = BAUD * 16 * 2;
    localparam int MEM_SIZE    = 3901;
    localparam int ADDR_W      = 20;
    localparam int TIMEOUT_CYC = 2000;
    localparam int BIT_CYC     = 32;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic uart_rx = 1'b1;

    uart_sample_loader_if #(.ADDR_W(ADDR_W)) bus();

    uart_sample_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .MEM_SIZE(MEM_SIZE),
        .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int kind;   // 0 write, 1 done, 2 error
        int addr;
        int data;   // write byte, or expected sample_count for done/error
        int lat;    // cycles from last write to the pulse, 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   last_we_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic exp_w(input int addr, input int data);
        exp_t e;
        e.kind = 0; e.addr = addr; e.data = data; e.lat = 0;
        exp_q.push_back(e);
    endtask

    task automatic exp_end(input int kind, input int count, input int lat);
        exp_t e;
        e.kind = kind; e.addr = 0; e.data = count; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT_CYC) @(negedge CLK);
        end
        uart_rx = 1'b1;
        repeat (BIT_CYC) @(negedge CLK);
    endtask

    // Bytes are listed first-sent in the most significant position.
    task automatic send_frame(input logic [63:0] bytes, input int n);
        for (int k = 0; k < n; k++) send_byte(bytes[8*(n-1-k) +: 8]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_we"},       32'(bus.mem_we), 0);
        check({tag, "_mem_addr"},     32'(bus.mem_addr), 0);
        check({tag, "_mem_data"},     32'(bus.mem_data), 0);
        check({tag, "_busy"},         32'(bus.busy), 0);
        check({tag, "_load_done"},    32'(bus.load_done), 0);
        check({tag, "_load_error"},   32'(bus.load_error), 0);
        check({tag, "_sample_count"}, 32'(bus.sample_count), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a result pulse.
    initial begin
        exp_t e;
        int   obs;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RESET) begin
                if (bus.mem_we) begin
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_write: got addr %0h data %0h, none expected", bus.mem_addr, bus.mem_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_write", 0, e.kind);
                        check("write_addr", 32'(bus.mem_addr), e.addr);
                        check("write_data", 32'(bus.mem_data), e.data);
                        check("busy_during_write", 32'(bus.busy), 1);
                    end
                    last_we_cyc = cyc;
                end
                if (bus.load_done || bus.load_error) begin
                    obs = bus.load_done ? 1 : 2;
                    if (exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_pulse: got done %0b error %0b, none expected", bus.load_done, bus.load_error);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind_pulse", obs, e.kind);
                        check("pulse_exclusive", 32'(bus.load_done & bus.load_error), 0);
                        check("sample_count", 32'(bus.sample_count), e.data);
                        check("busy_at_pulse", 32'(bus.busy), 0);
                        if (e.lat > 0) check("timeout_latency", cyc - last_we_cyc, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESET = 1'b0;
        repeat (5) @(negedge CLK);

        // Good frame
        exp_w(0, 'h10); exp_w(1, 'h20); exp_w(2, 'h30); exp_end(1, 3, 0);
        send_frame({8'hA5, 8'h03, 8'h00, 8'h10, 8'h20, 8'h30, 8'h60}, 7);

        // Bad checksum: writes happen, count kept
        exp_w(0, 'h01); exp_w(1, 'h02); exp_end(2, 3, 0);
        send_frame({8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h04}, 6);

        // Length 0 and length MEM_SIZE+1
        exp_end(2, 3, 0);
        send_frame({8'hA5, 8'h00, 8'h00}, 3);
        exp_end(2, 3, 0);
        send_frame({8'hA5, 8'h3E, 8'h0F}, 3);

        // Noise byte and a short start glitch are ignored
        send_frame({8'h55}, 1);
        uart_rx = 1'b0;
        repeat (5) @(negedge CLK);
        uart_rx = 1'b1;
        repeat (60) @(negedge CLK);

        // Good frame whose checksum wraps to 00
        exp_w(0, 'h7F); exp_w(1, 'h81); exp_end(1, 2, 0);
        send_frame({8'hA5, 8'h02, 8'h00, 8'h7F, 8'h81, 8'h00}, 6);

        // Inter-byte timeout
        exp_w(0, 'h11); exp_end(2, 2, TIMEOUT_CYC);
        send_frame({8'hA5, 8'h04, 8'h00, 8'h11}, 4);
        repeat (TIMEOUT_CYC + 300) @(negedge CLK);

        // Reset while the byte for address 1 is arriving
        exp_w(0, 'hAA);
        send_frame({8'hA5, 8'h04, 8'h00, 8'hAA}, 4);
        uart_rx = 1'b0;
        repeat (BIT_CYC) @(negedge CLK);
        uart_rx = 1'b1;
        repeat (3 * BIT_CYC) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check_reset_outputs("midframe_reset");
        RESET = 1'b0;
        repeat (10 * BIT_CYC) @(negedge CLK);

        // Single-sample frame after reset
        exp_w(0, 'h5A); exp_end(1, 1, 0);
        send_frame({8'hA5, 8'h01, 8'h00, 8'h5A, 8'h5A}, 5);
        repeat (400) @(negedge CLK);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
